// File: rtl/input_port_credit_pkg.sv
// Shared NoC types and helpers for the credit-based router input port.
// Holds the flit/port/VC-state types, the XY route function and flit helpers.
package input_port_credit_pkg;

  localparam int MESH_SIZE_X      = 4;
  localparam int MESH_SIZE_Y      = 4;
  localparam int DEST_ADDR_SIZE_X = 2;
  localparam int DEST_ADDR_SIZE_Y = 2;
  localparam int VC_NUM           = 2;
  localparam int VC_SIZE          = 2;
  localparam int DATA_SIZE        = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VA     = 2'd1,
    ACTIVE = 2'd2
  } vc_state_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [DATA_SIZE-1:0]        data;
  } flit_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [DATA_SIZE-1:0]        data;
  } flit_novc_t;

  typedef struct packed {
    flit_novc_t flit;
    port_t      route;
  } fifo_entry_t;

  // XY dimension-order routing: resolve x first, then y (north = smaller y).
  function automatic port_t rc_unit(input logic [DEST_ADDR_SIZE_X-1:0] x_dest,
                                    input logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
                                    input int x_cur, input int y_cur);
    port_t route;
    if (int'(x_dest) > x_cur) begin
      route = EAST;
    end else if (int'(x_dest) < x_cur) begin
      route = WEST;
    end else if (int'(y_dest) < y_cur) begin
      route = NORTH;
    end else if (int'(y_dest) > y_cur) begin
      route = SOUTH;
    end else begin
      route = LOCAL;
    end
    return route;
  endfunction

  function automatic logic is_head_label(input flit_label_t lab);
    return (lab == HEAD) || (lab == HEADTAIL);
  endfunction

  function automatic logic is_tail_label(input flit_label_t lab);
    return (lab == TAIL) || (lab == HEADTAIL);
  endfunction

  function automatic flit_novc_t strip_vc(input flit_t f);
    flit_novc_t n;
    n.flit_label = f.flit_label;
    n.x_dest     = f.x_dest;
    n.y_dest     = f.y_dest;
    n.data       = f.data;
    return n;
  endfunction

  function automatic flit_t add_vc(input flit_novc_t n, input logic [VC_SIZE-1:0] vc);
    flit_t f;
    f.flit_label = n.flit_label;
    f.vc_id      = vc;
    f.x_dest     = n.x_dest;
    f.y_dest     = n.y_dest;
    f.data       = n.data;
    return f;
  endfunction

endpackage

// File: rtl/input_port_credit_if.sv
// Link-side, allocator-side and crossbar-side signals of the input port.
// slave is the input port's view, master the surrounding router's view.
interface input_port_credit_if
  import input_port_credit_pkg::*;
#(
  parameter int VC_COUNT = VC_NUM
);

  flit_t                             data_i;
  logic                              valid_flit_i;
  logic [VC_SIZE-1:0]                vc_sel_i;
  logic                              valid_sel_i;
  logic [VC_COUNT-1:0][VC_SIZE-1:0]  vc_new_i;
  logic [VC_COUNT-1:0]               vc_valid_i;

  flit_t                             flit_o;
  logic                              valid_flit_o;
  logic [VC_COUNT-1:0]               credit_o;
  logic [VC_COUNT-1:0]               vc_request_o;
  logic [VC_COUNT-1:0]               switch_request_o;
  port_t [VC_COUNT-1:0]              out_port_o;
  logic [VC_COUNT-1:0][VC_SIZE-1:0]  downstream_vc_o;
  logic [VC_COUNT-1:0]               is_full_o;
  logic [VC_COUNT-1:0]               is_empty_o;
  logic [VC_COUNT-1:0]               error_o;

  modport slave (
    input  data_i, valid_flit_i, vc_sel_i, valid_sel_i, vc_new_i, vc_valid_i,
    output flit_o, valid_flit_o, credit_o, vc_request_o, switch_request_o,
           out_port_o, downstream_vc_o, is_full_o, is_empty_o, error_o
  );

  modport master (
    output data_i, valid_flit_i, vc_sel_i, valid_sel_i, vc_new_i, vc_valid_i,
    input  flit_o, valid_flit_o, credit_o, vc_request_o, switch_request_o,
           out_port_o, downstream_vc_o, is_full_o, is_empty_o, error_o
  );

endinterface

// File: rtl/input_port_credit_vc_fifo.sv
// Per-VC circular flit buffer storing each flit beside its precomputed route.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module vc_fifo
  import input_port_credit_pkg::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  fifo_entry_t i_entry,
  output fifo_entry_t o_front,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);

  fifo_entry_t      r_mem [BUFFER_SIZE];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == (PTR_W+1)'(BUFFER_SIZE));
  assign o_empty   = (r_count == {(PTR_W+1){1'b0}});
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_front   = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers wrap naturally modulo the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_credit.sv
// Credit-based router input port: per-VC buffers, IDLE/VA/ACTIVE state machines,
// registered crossbar flit with downstream VC rewrite, credit pulses and sticky errors.
module input_port_credit
  import input_port_credit_pkg::*;
#(
  parameter int VC_COUNT    = VC_NUM,
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT   = MESH_SIZE_X / 2,
  parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
  input logic                 clk,
  input logic                 rst,
  input_port_credit_if.slave  bus
);

  vc_state_t                        r_state [VC_COUNT];
  port_t [VC_COUNT-1:0]             r_out_port;
  logic [VC_COUNT-1:0][VC_SIZE-1:0] r_down_vc;
  logic [VC_COUNT-1:0]              r_error;
  logic [VC_COUNT-1:0]              r_credit;
  flit_t                            r_flit;
  logic                             r_valid;

  fifo_entry_t          w_front [VC_COUNT];
  fifo_entry_t          w_wr_entry;
  flit_t                w_out_flit;
  logic                 w_vc_oob;
  logic [VC_COUNT-1:0]  w_full, w_empty;
  logic [VC_COUNT-1:0]  w_wr_hit, w_push, w_pop, w_sel_pop, w_discard;
  logic [VC_COUNT-1:0]  w_wr_err, w_rd_err, w_err_set;

  // Write steering, pop qualification, discard of headless fronts and error sources.
  always_comb begin
    w_vc_oob         = bus.valid_flit_i &&
                       ({1'b0, bus.data_i.vc_id} >= (VC_SIZE+1)'(VC_COUNT));
    w_wr_entry.flit  = strip_vc(bus.data_i);
    w_wr_entry.route = rc_unit(bus.data_i.x_dest, bus.data_i.y_dest, X_CURRENT, Y_CURRENT);
    w_out_flit       = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      w_wr_hit[v]  = bus.valid_flit_i && !w_vc_oob && (bus.data_i.vc_id == VC_SIZE'(v));
      w_discard[v] = (r_state[v] == IDLE) && !w_empty[v] &&
                     !is_head_label(w_front[v].flit.flit_label);
      w_sel_pop[v] = bus.valid_sel_i && (bus.vc_sel_i == VC_SIZE'(v)) &&
                     (r_state[v] == ACTIVE) && !w_empty[v];
      w_rd_err[v]  = bus.valid_sel_i && (bus.vc_sel_i == VC_SIZE'(v)) && !w_sel_pop[v];
      w_pop[v]     = w_sel_pop[v] || w_discard[v];
      w_push[v]    = w_wr_hit[v] && (!w_full[v] || w_pop[v]);
      w_wr_err[v]  = w_wr_hit[v] && w_full[v] && !w_pop[v];
      w_out_flit   = w_sel_pop[v] ? add_vc(w_front[v].flit, r_down_vc[v]) : w_out_flit;
    end
    w_err_set = w_discard | w_wr_err | w_rd_err | {VC_COUNT{w_vc_oob}};
  end

  for (genvar g = 0; g < VC_COUNT; g++) begin : g_vc
    vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_entry (w_wr_entry),
      .o_front (w_front[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // Per-VC state machines plus the crossbar output, credit and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_COUNT; v++) r_state[v] <= IDLE;
      r_out_port <= '0;
      r_down_vc  <= '0;
      r_error    <= '0;
      r_credit   <= '0;
      r_flit     <= '0;
      r_valid    <= 1'b0;
    end else begin
      for (int v = 0; v < VC_COUNT; v++) begin
        case (r_state[v])
          IDLE: begin
            if (!w_empty[v] && is_head_label(w_front[v].flit.flit_label)) begin
              r_state[v]    <= VA;
              r_out_port[v] <= w_front[v].route;
            end
          end
          VA: begin
            if (bus.vc_valid_i[v]) begin
              r_state[v]   <= ACTIVE;
              r_down_vc[v] <= bus.vc_new_i[v];
            end
          end
          ACTIVE: begin
            if (w_sel_pop[v] && is_tail_label(w_front[v].flit.flit_label)) begin
              r_state[v] <= IDLE;
            end
          end
          default: r_state[v] <= IDLE;
        endcase
      end
      r_error  <= r_error | w_err_set;
      r_credit <= w_pop;
      r_valid  <= |w_sel_pop;
      if (|w_sel_pop) r_flit <= w_out_flit;
    end
  end

  always_comb begin
    for (int v = 0; v < VC_COUNT; v++) begin
      bus.vc_request_o[v]     = (r_state[v] == VA);
      bus.switch_request_o[v] = (r_state[v] == ACTIVE) && !w_empty[v];
    end
  end

  assign bus.flit_o          = r_flit;
  assign bus.valid_flit_o    = r_valid;
  assign bus.credit_o        = r_credit;
  assign bus.out_port_o      = r_out_port;
  assign bus.downstream_vc_o = r_down_vc;
  assign bus.is_full_o       = w_full;
  assign bus.is_empty_o      = w_empty;
  assign bus.error_o         = r_error;

endmodule
